fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised instruction buffer between fetch and decode; the next generation of the single-entry IF/ID register.
- Holds up to DEPTH fetched (pc, inst) pairs, so fetch keeps running while decode is stalled.
- Uses valid/ready handshakes on both sides instead of a stall vector.
- Supports synchronous flush (branch redirect or exception) and presents zeroed pc/inst as a bubble whenever empty.

Parameters:
- ADDR_W, 32, PC width.
- INST_W, 32, instruction width.
- DEPTH, 4, entry count; must be a power of two and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered entries this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_pc  in  ADDR_W  fetch PC.
- in_inst  in  INST_W  fetched instruction.
- in_ready  out  1  queue can accept (not full).
- out_valid  out  1  head entry valid.
- out_pc  out  ADDR_W  head PC; zero when out_valid=0.
- out_inst  out  INST_W  head instruction; zero when out_valid=0.
- out_ready  in  1  decode consumes head (equivalent to decode not stalled).
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=0, rd_ptr=0, count=0. Consequently out_valid=0, out_pc=0, out_inst=0, in_ready=1. Storage contents need no reset.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N (next cycle). There is no same-cycle bypass.
- out_valid = (count != 0). out_pc/out_inst = storage[rd_ptr] when out_valid, else zero (bubble, ZeroWord).
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count distinguishes full from empty.
- Push only: write storage[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (any occupancy from 1 to DEPTH-1): write and advance both pointers; count is unchanged.
- When full, in_ready=0, so no push occurs even if out_ready=1. Occupancy drops by one that cycle.
- When empty, no pop occurs (out_valid=0) regardless of out_ready.
- Flush: at the next edge wr_ptr=rd_ptr=count=0. Any push or pop that cycle is ignored and the incoming instruction is dropped. Priority: rst > flush > push/pop.
- Reset or flush asserted mid-stream drops all pending entries. out_valid is 0 the following cycle.
- in_pc/in_inst are don't-care when in_valid=0.

Decomposition:
- Shared defines file holds the reset polarity (RstEnable), ZeroWord, and the default PC/instruction bus widths (InstAddrBus, InstBus). ADDR_W and INST_W default from these.
- One sub-module, fetch_queue_mem: DEPTH x (ADDR_W+INST_W) register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic stays in fetch_queue.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, out_inst=0, count=0, in_ready=1.
- Fill: out_ready=0; push pc 0x100, 0x104, 0x108, 0x10C with inst 0xA0..0xA3 -> count=4, in_ready=0. A fifth push of pc 0x110 is ignored, and out_pc=0x100 throughout.
- Drain and order: then out_ready=1, in_valid=0 -> out_pc reads 0x100, 0x104, 0x108, 0x10C on consecutive cycles. After that, out_valid=0 and out_pc=0.
- Simultaneous and wrap-around: keep count=2 while pushing and popping every cycle for 10 cycles with pc incrementing by 4 -> count stays 2, order is preserved across the pointer wrap, and there is no loss or duplication.
- Flush: count=3 with flush=1 and a concurrent push of 0x200 -> next cycle count=0 and out_valid=0. The next push of 0x300 appears at the head one cycle later.
- Reset mid-stream: count=2 with rst=1 and a concurrent pop -> all state clears as in the reset scenario, and no stale pc appears afterwards.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch/decode instruction buffer: reset polarity,
// bubble value, default bus widths and the per-cycle queue operation encoding.
package fetch_queue_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Bit 1 = accepted push, bit 0 = accepted pop.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshakes of the instruction buffer, plus flush
// and occupancy. The slave modport is the queue's view.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int DEPTH  = 4
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH (pc, inst) entries with
// valid/ready on both sides, synchronous flush, and a zero bubble when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int INST_W = InstBus,
  parameter int DEPTH  = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_W + INST_W;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [ENT_W-1:0] head;
  logic             in_rdy;
  logic             out_vld;
  logic             push;
  logic             pop;
  logic             mem_we;
  fq_op_e           op;

  // Readiness comes from registered occupancy only, so out_ready never
  // reaches in_ready combinationally; a full queue therefore refuses a push
  // even in a cycle where it is also popping.
  assign in_rdy  = (count_q != CNT_W'(DEPTH));
  assign out_vld = (count_q != '0);
  assign push    = bus.in_valid & in_rdy;
  assign pop     = out_vld & bus.out_ready;
  assign op      = fq_op_e'({push, pop});
  assign mem_we  = push & ~bus.flush & (rst != RstEnable);

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata ({bus.in_pc, bus.in_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers wrap naturally at DEPTH; count tells full from empty.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      unique case (op)
        FQ_PUSH: begin
          wr_ptr  <= wr_ptr + PTR_W'(1);
          count_q <= count_q + CNT_W'(1);
        end
        FQ_POP: begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          count_q <= count_q - CNT_W'(1);
        end
        FQ_BOTH: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.count     = count_q;
  assign bus.out_pc    = out_vld ? head[ENT_W-1 -: ADDR_W] : ADDR_W'(ZeroWord);
  assign bus.out_inst  = out_vld ? head[INST_W-1:0]        : INST_W'(ZeroWord);

endmodule
